// File: rtl/sym_packer.sv
// Receive-side symbol packer: gathers SYM_W-bit symbols into SYMS-symbol words
// (first symbol in the LSBs) and queues completed or flushed words in a small FIFO.
module sym_packer #(
    parameter int SYM_W = 3,
    parameter int SYMS  = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_valid,
    input  logic [SYM_W-1:0]             a,
    output logic                         a_ready,
    input  logic                         flush,
    output logic                         word_valid,
    output logic [SYM_W*SYMS-1:0]        word_data,
    output logic [$clog2(SYMS+1)-1:0]    word_fill,
    input  logic                         word_ready,
    output logic [15:0]                  sym_cnt
);
    localparam int W  = SYM_W * SYMS;
    localparam int CW = $clog2(SYMS);
    localparam int FW = $clog2(SYMS + 1);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  pack_q, pack_n, pack_acc, ins;
    logic [CW-1:0] c_q, c_n;
    logic [FW-1:0] fill_acc, push_fill;
    logic [W-1:0]  push_data;
    logic          flush_pend_q, pend_n;
    logic          accept, pop, push, fifo_full;

    logic [W-1:0]  mem_data [DEPTH];
    logic [FW-1:0] mem_fill [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   occ_q;

    always_comb begin
        fifo_full = (occ_q == (PW+1)'(DEPTH));
        a_ready   = !flush_pend_q && ((c_q != CW'(SYMS - 1)) || !fifo_full);
        accept    = a_valid && a_ready;
        pop       = word_valid && word_ready;
        ins       = W'(a) << (c_q * SYM_W);
        pack_acc  = accept ? (pack_q | ins) : pack_q;
        fill_acc  = FW'(c_q) + FW'(accept);

        push      = 1'b0;
        push_data = pack_acc;
        push_fill = fill_acc;
        pack_n    = pack_acc;
        c_n       = c_q + CW'(accept);
        pend_n    = flush_pend_q;

        // A pending flush waits for space; a pop on this edge frees a slot.
        if (flush_pend_q) begin
            if (!fifo_full || pop) begin
                push      = 1'b1;
                push_data = pack_q;
                push_fill = FW'(c_q);
                pack_n    = '0;
                c_n       = '0;
                pend_n    = 1'b0;
            end
        end else if (fill_acc == FW'(SYMS)) begin
            push   = 1'b1;
            pack_n = '0;
            c_n    = '0;
        end else if (flush && (fill_acc != '0)) begin
            if (!fifo_full) begin
                push   = 1'b1;
                pack_n = '0;
                c_n    = '0;
            end else begin
                pend_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q       <= '0;
            c_q          <= '0;
            flush_pend_q <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ_q        <= '0;
            sym_cnt      <= '0;
        end else begin
            pack_q       <= pack_n;
            c_q          <= c_n;
            flush_pend_q <= pend_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            if (accept) sym_cnt <= sym_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_fill[wr_ptr] <= push_fill;
        end
    end

    assign word_valid = (occ_q != '0);
    assign word_data  = word_valid ? mem_data[rd_ptr] : '0;
    assign word_fill  = word_valid ? mem_fill[rd_ptr] : '0;
endmodule

// File: tb/tb_sym_packer.sv
// Bench for sym_packer: directed scenarios plus randomized traffic against a
// queue-based model of the packing and FIFO rules.
module tb_sym_packer;
    localparam int SYM_W = 3;
    localparam int SYMS  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, a_valid, flush, word_ready;
    logic [2:0]  a;
    logic        a_ready, word_valid;
    logic [11:0] word_data;
    logic [2:0]  word_fill;
    logic [15:0] sym_cnt;

    int checks = 0;
    int errors = 0;

    int          mq_d[$];
    int          mq_f[$];
    int          pk[$];
    bit          m_pend;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    sym_packer #(.SYM_W(SYM_W), .SYMS(SYMS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .a_valid(a_valid), .a(a), .a_ready(a_ready),
        .flush(flush), .word_valid(word_valid), .word_data(word_data),
        .word_fill(word_fill), .word_ready(word_ready), .sym_cnt(sym_cnt)
    );

    function automatic bit m_ready();
        return !m_pend && (pk.size() != SYMS - 1 || mq_d.size() < DEPTH);
    endfunction

    function automatic int pack_pk();
        int w = 0;
        foreach (pk[i]) w += pk[i] * (1 << (i * SYM_W));
        return w;
    endfunction

    task automatic emit();
        mq_d.push_back(pack_pk());
        mq_f.push_back(pk.size());
        pk.delete();
    endtask

    task automatic model_edge();
        bit acc, pop, was_full;
        if (rst) begin
            mq_d.delete(); mq_f.delete(); pk.delete();
            m_pend = 0; m_cnt = '0;
            return;
        end
        acc      = a_valid && m_ready();
        pop      = word_ready && mq_d.size() > 0;
        was_full = mq_d.size() == DEPTH;
        if (pop) begin
            void'(mq_d.pop_front());
            void'(mq_f.pop_front());
        end
        if (m_pend) begin
            if (!was_full || pop) begin emit(); m_pend = 0; end
        end else begin
            if (acc) begin pk.push_back(int'(a)); m_cnt = m_cnt + 16'd1; end
            if (pk.size() == SYMS) emit();
            else if (flush && pk.size() > 0) begin
                if (!was_full) emit();
                else m_pend = 1;
            end
        end
    endtask

    task automatic cyc(input bit av, input int sym, input bit fl, input bit wr);
        @(negedge clk);
        a_valid = av; a = 3'(sym); flush = fl; word_ready = wr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic reset_dut();
        rst = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %0b want 1", a_ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %0b want 0", word_valid); end
        checks++; if (word_data !== 12'h0) begin errors++; $display("FAIL reset_word_data got %h want 000", word_data); end
        checks++; if (word_fill !== 3'd0) begin errors++; $display("FAIL reset_word_fill got %0d want 0", word_fill); end
        checks++; if (sym_cnt !== 16'd0) begin errors++; $display("FAIL reset_sym_cnt got %0d want 0", sym_cnt); end
    endtask

    task automatic test_basic();
        int s[4] = '{5, 3, 7, 1};
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL basic_a_ready[%0d] got %0b want 1", i, a_ready); end
            cyc(1, s[i], 0, 1);
        end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", word_valid); end
        checks++; if (word_data !== 12'h3DD) begin errors++; $display("FAIL basic_data got %h want 3dd", word_data); end
        checks++; if (word_fill !== 3'd4) begin errors++; $display("FAIL basic_fill got %0d want 4", word_fill); end
        checks++; if (sym_cnt !== 16'd4) begin errors++; $display("FAIL basic_cnt got %0d want 4", sym_cnt); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL basic_a_ready_after got %0b want 1", a_ready); end
        cyc(0, 0, 0, 1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_popped got %0b want 0", word_valid); end
    endtask

    task automatic test_fill_stall();
        int acc = 0;
        int syms[$];
        int s, w;
        reset_dut();
        repeat (30) begin
            s = $urandom_range(0, 7);
            if (m_ready()) begin acc++; syms.push_back(s); end
            cyc(1, s, 0, 0);
        end
        checks++; if (acc != 19) begin errors++; $display("FAIL stall_accepts got %0d want 19", acc); end
        checks++; if (sym_cnt !== 16'd19) begin errors++; $display("FAIL stall_cnt got %0d want 19", sym_cnt); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_a_ready got %0b want 0", a_ready); end
        for (int i = 0; i < 4; i++) begin
            w = syms[4*i] + syms[4*i+1] * 8 + syms[4*i+2] * 64 + syms[4*i+3] * 512;
            checks++; if (word_valid !== 1'b1 || word_data !== 12'(w))
                begin errors++; $display("FAIL stall_word[%0d] got v=%0b %h want v=1 %h", i, word_valid, word_data, 12'(w)); end
            cyc(0, 0, 0, 1);
            if (i == 0) begin
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_return got %0b want 1", a_ready); end
            end
        end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %0b want 0", word_valid); end
    endtask

    task automatic test_flush_partial();
        reset_dut();
        cyc(1, 6, 0, 1);
        cyc(1, 2, 0, 1);
        cyc(0, 0, 1, 1);
        checks++; if (word_valid !== 1'b1 || word_data !== 12'h016 || word_fill !== 3'd2)
            begin errors++; $display("FAIL flush_partial got v=%0b %h f=%0d want v=1 016 f=2", word_valid, word_data, word_fill); end
        cyc(1, 5, 0, 1);
        cyc(0, 0, 1, 1);
        checks++; if (word_valid !== 1'b1 || word_data !== 12'h005 || word_fill !== 3'd1)
            begin errors++; $display("FAIL flush_next_lsb got v=%0b %h f=%0d want v=1 005 f=1", word_valid, word_data, word_fill); end
    endtask

    task automatic test_flush_same();
        reset_dut();
        cyc(1, 4, 0, 1);
        cyc(1, 1, 1, 1);
        checks++; if (word_valid !== 1'b1 || word_data !== 12'h00C || word_fill !== 3'd2)
            begin errors++; $display("FAIL flush_same got v=%0b %h f=%0d want v=1 00c f=2", word_valid, word_data, word_fill); end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got v=%0b want 0", word_valid); end
        cyc(0, 0, 0, 1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_late got v=%0b want 0", word_valid); end
    endtask

    task automatic test_flush_full();
        int s0 = 0, s1 = 0, s;
        reset_dut();
        for (int i = 0; i < 18; i++) begin
            s = $urandom_range(0, 7);
            if (i == 16) s0 = s;
            if (i == 17) s1 = s;
            cyc(1, s, 0, 0);
        end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ffull_ready_pre got %0b want 1", a_ready); end
        cyc(0, 0, 1, 0);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL ffull_ready_pend got %0b want 0", a_ready); end
        cyc(1, 3, 0, 0);
        checks++; if (a_ready !== 1'b0 || sym_cnt !== 16'd18)
            begin errors++; $display("FAIL ffull_hold got r=%0b cnt=%0d want r=0 cnt=18", a_ready, sym_cnt); end
        cyc(0, 0, 0, 1);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ffull_ready_post got %0b want 1", a_ready); end
        repeat (3) cyc(0, 0, 0, 1);
        checks++; if (word_valid !== 1'b1 || word_data !== 12'(s0 + s1 * 8) || word_fill !== 3'd2)
            begin errors++; $display("FAIL ffull_padded got v=%0b %h f=%0d want v=1 %h f=2", word_valid, word_data, word_fill, 12'(s0 + s1 * 8)); end
        cyc(0, 0, 0, 1);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ffull_occupancy got v=%0b want 0", word_valid); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        repeat (14) cyc(1, $urandom_range(0, 7), 0, 0);
        rst = 1;
        cyc(1, 7, 1, 0);
        rst = 0;
        checks++; if (a_ready !== 1'b1 || word_valid !== 1'b0 || word_data !== 12'h0 || word_fill !== 3'd0 || sym_cnt !== 16'd0)
            begin errors++; $display("FAIL rstmid_outputs got r=%0b v=%0b %h f=%0d c=%0d want 1 0 000 0 0", a_ready, word_valid, word_data, word_fill, sym_cnt); end
        cyc(1, 2, 0, 0); cyc(1, 4, 0, 0); cyc(1, 6, 0, 0); cyc(1, 0, 0, 0);
        checks++; if (word_valid !== 1'b1 || word_data !== 12'h1A2 || word_fill !== 3'd4)
            begin errors++; $display("FAIL rstmid_word got v=%0b %h f=%0d want v=1 1a2 f=4", word_valid, word_data, word_fill); end
        cyc(0, 0, 0, 1);
        checks++; if (word_valid !== 1'b0 || sym_cnt !== 16'd4)
            begin errors++; $display("FAIL rstmid_remnant got v=%0b cnt=%0d want v=0 cnt=4", word_valid, sym_cnt); end
    endtask

    task automatic test_random();
        int ed, ef;
        bit ev;
        reset_dut();
        repeat (600) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            ev = mq_d.size() != 0;
            ed = ev ? mq_d[0] : 0;
            ef = ev ? mq_f[0] : 0;
            checks++; if (a_ready !== m_ready()) begin errors++; $display("FAIL rnd_a_ready got %0b want %0b", a_ready, m_ready()); end
            checks++; if (word_valid !== ev) begin errors++; $display("FAIL rnd_valid got %0b want %0b", word_valid, ev); end
            checks++; if (word_data !== 12'(ed)) begin errors++; $display("FAIL rnd_data got %h want %h", word_data, 12'(ed)); end
            checks++; if (word_fill !== 3'(ef)) begin errors++; $display("FAIL rnd_fill got %0d want %0d", word_fill, ef); end
            checks++; if (sym_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt got %0d want %0d", sym_cnt, m_cnt); end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; a_valid = 0; a = '0; flush = 0; word_ready = 0;
        m_pend = 0; m_cnt = '0;
        test_reset();
        test_basic();
        test_fill_stall();
        test_flush_partial();
        test_flush_same();
        test_flush_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
